psram_backend: RTL and testbench
================================

# psram_backend

Memory-side responder for the `dualport_frontend` request interface. It accepts one arbitrated word read, 4-word page-mode burst read, or word write per transaction. It drives the on-board asynchronous cellular PSRAM with parameterised wait-state timing and returns the `op_begun`, `data_ok` and `op_finished` strobes the frontend arbitrates on.

## Interface
Parameters:
- `T_RD`, 4: cycles `ce_n`/`oe_n` are held low before the first read word is captured; range 2–15.
- `T_PAGE`, 2: cycles per subsequent page-mode word; range 1–15.
- `T_WR`, 4: cycles `we_n` is held low; range 2–15.
- `T_GAP`, 1: cycles `ce_n` is held high between transactions; range 1–15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `app_data_wr`  in  16  write data from the frontend.
- `app_addr`  in  23  word address.
- `app_wr`  in  1  write request.
- `app_rd`  in  1  read request.
- `app_burst`  in  1  qualifies `app_rd` as a 4-word burst; ignored for writes.
- `op_begun`  out  1  one-cycle pulse when a transaction is accepted.
- `data_ok`  out  1  one-cycle pulse when `data_rd` holds a new word.
- `op_finished`  out  1  one-cycle pulse when the next request may be issued.
- `data_rd`  out  16  registered read word.
- `mem_addr`  out  23  PSRAM address bus.
- `mem_dq_o`  out  16  PSRAM write data.
- `mem_dq_oe`  out  1  tristate enable for the DQ pads.
- `mem_dq_i`  in  16  PSRAM read data.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1 each  PSRAM controls.
- `mem_adv_n`, `mem_clk`, `mem_cre`, `mem_ub_n`, `mem_lb_n`  out  1 each  tied 0 (asynchronous mode, full word access).

## Operation
- FSM states:
  - IDLE → RD_ACC | WR_ACC.
  - RD_ACC → RD_PAGE | RECOVER.
  - RD_PAGE → RD_PAGE | RECOVER.
  - WR_ACC → WR_HOLD → RECOVER.
  - RECOVER → IDLE.
- Requests are sampled only in IDLE. One cycle of `app_wr` or `app_rd` is sufficient. If both are high, write wins.
- On acceptance, address, data and burst are latched. Requests arriving outside IDLE are ignored; the frontend waits for `op_finished`.
- Read:
  - RD_ACC holds `ce_n`=`oe_n`=0 for `T_RD` cycles. `mem_dq_i` is captured on the last RD_ACC edge.
  - For a burst, RD_PAGE then runs 3 times, `T_PAGE` cycles each. `mem_addr[1:0]` increments and wraps within the aligned 4-word group; `mem_addr[22:2]` is fixed.
  - Each capture produces `data_ok` in the following cycle.
- Write:
  - WR_ACC holds `ce_n`=`we_n`=0 and `mem_dq_oe`=1 with `mem_dq_o` = latched data for `T_WR` cycles.
  - WR_HOLD (1 cycle) keeps `ce_n`=0, `we_n`=1 and `mem_dq_oe`=1 for data hold.
  - No `data_ok` is produced for writes.
- RECOVER holds `ce_n`=`oe_n`=`we_n`=1 and `mem_dq_oe`=0 for `T_GAP` cycles. `op_finished` pulses in its last cycle.
- `mem_dq_oe` is 1 only in WR_ACC and WR_HOLD. `oe_n` and `we_n` are never both low.
- Reset (asserted asynchronously, including mid-transaction):
  - FSM → IDLE.
  - `mem_ce_n`, `mem_oe_n`, `mem_we_n` = 1.
  - `mem_dq_oe`, `mem_addr`, `mem_dq_o`, `data_rd`, `op_begun`, `data_ok`, `op_finished` = 0.
  - The interrupted transaction is dropped with no `op_finished`.

## Timing
Cycle 0 is the IDLE cycle in which the request is seen.
- All outputs are registered.
- `op_begun` and the first active memory cycle fall in cycle 1.
- Single read: `data_ok` in cycle `T_RD`+1. RECOVER occupies cycles `T_RD`+1 .. `T_RD`+`T_GAP`, with `op_finished` in the last of them.
- Burst read: `data_ok` in cycles `T_RD`+1+k·`T_PAGE`, k=0..3. RECOVER starts the cycle after the last capture.
- Write: WR_HOLD in cycle `T_WR`+1. `op_finished` in cycle `T_WR`+1+`T_GAP`.
- A request in the cycle after `op_finished` is accepted; back-to-back throughput has no extra bubble.

## Structure
- Package `psram_pkg` holds:
  - `ADDR_W`=23 and `DATA_W`=16;
  - the FSM state enum;
  - `BURST_LEN`=4.
- Sub-module `psram_wait_counter`: 4-bit loadable down-counter with a `done` flag. The FSM loads it with `T_RD`, `T_PAGE`, `T_WR` or `T_GAP` on each state entry.

## Test plan
- Default parameters, one-cycle `app_rd` at addr 23'h555555, PSRAM model returns 16'hA5A5 → `op_begun` @1, `ce_n`/`oe_n` low cycles 1–4, `data_rd`=16'hA5A5 with `data_ok` @5, `op_finished` @5.
- Burst read at 23'h70F0F2 → `mem_addr` low bits sequence 2,3,0,1; `data_ok` @5,7,9,11; `op_finished` @11; `mem_addr[22:2]` constant.
- Write 16'h1234 to 23'h0F0F0F → `we_n` low cycles 1–4, `dq_oe` high cycles 1–5, `oe_n` stays 1, `op_finished` @6; a read-back returns 16'h1234.
- `app_wr` and `app_rd` both high → write performed; second request raised mid-transaction → ignored; request in the cycle after `op_finished` → `op_begun` one cycle later.
- `reset` low in burst cycle 7 → all controls deasserted immediately, no further strobes; new read after release completes normally.
- `T_RD`=2, `T_PAGE`=1, `T_GAP`=3 → `data_ok` @3,4,5,6, `op_finished` @8.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared definitions for the asynchronous PSRAM back end: bus widths,
// burst geometry and the transaction FSM state encoding.
package psram_pkg;

  localparam int ADDR_W    = 23;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_RD_PAGE,
    S_WR_ACC,
    S_WR_HOLD,
    S_RECOVER
  } psram_state_e;

  // Chip enable is asserted for every access phase, never in IDLE/RECOVER.
  function automatic logic ce_active(input psram_state_e s);
    return (s == S_RD_ACC) || (s == S_RD_PAGE) || (s == S_WR_ACC) || (s == S_WR_HOLD);
  endfunction

  // Output enable only while the device is driving read data.
  function automatic logic oe_active(input psram_state_e s);
    return (s == S_RD_ACC) || (s == S_RD_PAGE);
  endfunction

  // Our DQ drivers are on while write data is presented and held.
  function automatic logic dq_drive(input psram_state_e s);
    return (s == S_WR_ACC) || (s == S_WR_HOLD);
  endfunction

endpackage

// File: rtl/psram_backend_if.sv
// Request/response bus between the dual-port frontend (master) and the
// PSRAM back end (slave).
interface psram_backend_if;
  import psram_pkg::*;

  logic [DATA_W-1:0] app_data_wr;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wr;
  logic              app_rd;
  logic              app_burst;
  logic              op_begun;
  logic              data_ok;
  logic              op_finished;
  logic [DATA_W-1:0] data_rd;

  modport master (
    output app_data_wr, app_addr, app_wr, app_rd, app_burst,
    input  op_begun, data_ok, op_finished, data_rd
  );

  modport slave (
    input  app_data_wr, app_addr, app_wr, app_rd, app_burst,
    output op_begun, data_ok, op_finished, data_rd
  );

endinterface

// File: rtl/psram_wait_counter.sv
// Loadable wait-state down-counter. A phase loaded with N lasts N cycles:
// done_o is high in the N-th cycle. done_next_o looks one cycle ahead so a
// registered strobe can land in that final cycle.
module psram_wait_counter
  import psram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o,
  output logic             done_next_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o      = (cnt_q == CNT_W'(1));
  assign done_next_o = (cnt_d == CNT_W'(1));

endmodule

// File: rtl/psram_backend.sv
// Memory-side responder for the dual-port frontend. Runs one word read,
// 4-word page-mode burst read or word write per transaction against an
// asynchronous cellular PSRAM, with all PSRAM pins and frontend strobes
// driven from registers.
module psram_backend
  import psram_pkg::*;
#(
  parameter int unsigned T_RD   = 4,
  parameter int unsigned T_PAGE = 2,
  parameter int unsigned T_WR   = 4,
  parameter int unsigned T_GAP  = 1
) (
  input  logic              clk,
  input  logic              reset,
  psram_backend_if.slave    bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_i,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_adv_n,
  output logic              mem_clk,
  output logic              mem_cre,
  output logic              mem_ub_n,
  output logic              mem_lb_n
);

  // Page beats after the initial access, counted 0..PAGE_LAST.
  localparam logic [1:0] PAGE_LAST = 2'(BURST_LEN - 2);

  psram_state_e      state_q;
  psram_state_e      state_d;
  logic              wait_done;
  logic              wait_done_next;
  logic              wait_load;
  logic [CNT_W-1:0]  wait_val;
  logic              accept;
  logic              capture;

  logic              burst_q;
  logic [1:0]        page_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_dq_o_q;
  logic [DATA_W-1:0] data_rd_q;
  logic              op_begun_q;
  logic              data_ok_q;
  logic              op_finished_q;
  logic              mem_ce_n_q;
  logic              mem_oe_n_q;
  logic              mem_we_n_q;
  logic              mem_dq_oe_q;

  psram_wait_counter u_wait (
    .clk         (clk),
    .reset       (reset),
    .load_i      (wait_load),
    .load_val_i  (wait_val),
    .done_o      (wait_done),
    .done_next_o (wait_done_next)
  );

  // Next-state logic; the wait counter is reloaded whenever a phase starts,
  // including each repeated page beat.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    wait_load = 1'b0;
    wait_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.app_wr) begin
          state_d = S_WR_ACC;
        end else if (bus.app_rd) begin
          state_d = S_RD_ACC;
        end
      end
      S_RD_ACC: begin
        if (wait_done) begin
          capture = 1'b1;
          state_d = burst_q ? S_RD_PAGE : S_RECOVER;
        end
      end
      S_RD_PAGE: begin
        if (wait_done) begin
          capture = 1'b1;
          state_d = (page_q == PAGE_LAST) ? S_RECOVER : S_RD_PAGE;
        end
      end
      S_WR_ACC: begin
        if (wait_done) begin
          state_d = S_WR_HOLD;
        end
      end
      S_WR_HOLD: begin
        if (wait_done) begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (wait_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept    = (state_q == S_IDLE) && (state_d != S_IDLE);
    wait_load = (state_d != S_IDLE) && ((state_d != state_q) || wait_done);
    case (state_d)
      S_RD_ACC:  wait_val = CNT_W'(T_RD);
      S_RD_PAGE: wait_val = CNT_W'(T_PAGE);
      S_WR_ACC:  wait_val = CNT_W'(T_WR);
      S_WR_HOLD: wait_val = CNT_W'(1);
      S_RECOVER: wait_val = CNT_W'(T_GAP);
      default:   wait_val = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered pins and strobes, decoded from the state being entered so
  // they line up with that state's cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_begun_q    <= 1'b0;
      data_ok_q     <= 1'b0;
      op_finished_q <= 1'b0;
      mem_ce_n_q    <= 1'b1;
      mem_oe_n_q    <= 1'b1;
      mem_we_n_q    <= 1'b1;
      mem_dq_oe_q   <= 1'b0;
      data_rd_q     <= '0;
      mem_addr_q    <= '0;
      mem_dq_o_q    <= '0;
      burst_q       <= 1'b0;
      page_q        <= '0;
    end else begin
      op_begun_q    <= accept;
      data_ok_q     <= capture;
      op_finished_q <= (state_d == S_RECOVER) && wait_done_next;
      mem_ce_n_q    <= !ce_active(state_d);
      mem_oe_n_q    <= !oe_active(state_d);
      mem_we_n_q    <= (state_d != S_WR_ACC);
      mem_dq_oe_q   <= dq_drive(state_d);
      if (capture) begin
        data_rd_q <= mem_dq_i;
      end
      if (accept) begin
        mem_addr_q <= bus.app_addr;
        mem_dq_o_q <= bus.app_data_wr;
        burst_q    <= bus.app_burst;
        page_q     <= '0;
      end else if (capture && (state_d == S_RD_PAGE)) begin
        // Page beats wrap inside the aligned 4-word group.
        mem_addr_q[1:0] <= mem_addr_q[1:0] + 2'd1;
        if (state_q == S_RD_PAGE) begin
          page_q <= page_q + 2'd1;
        end
      end
    end
  end

  assign bus.op_begun    = op_begun_q;
  assign bus.data_ok     = data_ok_q;
  assign bus.op_finished = op_finished_q;
  assign bus.data_rd     = data_rd_q;

  assign mem_addr  = mem_addr_q;
  assign mem_dq_o  = mem_dq_o_q;
  assign mem_dq_oe = mem_dq_oe_q;
  assign mem_ce_n  = mem_ce_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_we_n  = mem_we_n_q;

  // Asynchronous mode, full 16-bit access.
  assign mem_adv_n = 1'b0;
  assign mem_clk   = 1'b0;
  assign mem_cre   = 1'b0;
  assign mem_ub_n  = 1'b0;
  assign mem_lb_n  = 1'b0;

endmodule

// File: tb/tb_psram_backend.sv
// Bench for psram_backend: lane 0 uses default timing, lane 1 uses
// T_RD=2, T_PAGE=1, T_WR=2, T_GAP=3. Each lane has a PSRAM model; expected
// per-cycle behaviour is computed from the transaction timing rules.
module tb_psram_backend;
  import psram_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              app_wr_a    [2];
  logic              app_rd_a    [2];
  logic              app_burst_a [2];
  logic [ADDR_W-1:0] app_addr_a  [2];
  logic [DATA_W-1:0] app_data_a  [2];
  logic              begun_a     [2];
  logic              ok_a        [2];
  logic              fin_a       [2];
  logic [DATA_W-1:0] rd_a        [2];
  logic [ADDR_W-1:0] addr_a      [2];
  logic [DATA_W-1:0] dq_o_a      [2];
  logic              dq_oe_a     [2];
  logic [DATA_W-1:0] dq_i_a      [2];
  logic              ce_a        [2];
  logic              oe_a        [2];
  logic              we_a        [2];
  logic              adv_a       [2];
  logic              mclk_a      [2];
  logic              cre_a       [2];
  logic              ub_a        [2];
  logic              lb_a        [2];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned LRD = (g == 0) ? 4 : 2;
    localparam int unsigned LPG = (g == 0) ? 2 : 1;
    localparam int unsigned LWR = (g == 0) ? 4 : 2;
    localparam int unsigned LGP = (g == 0) ? 1 : 3;

    psram_backend_if bus ();

    assign bus.app_wr      = app_wr_a[g];
    assign bus.app_rd      = app_rd_a[g];
    assign bus.app_burst   = app_burst_a[g];
    assign bus.app_addr    = app_addr_a[g];
    assign bus.app_data_wr = app_data_a[g];
    assign begun_a[g]      = bus.op_begun;
    assign ok_a[g]         = bus.data_ok;
    assign fin_a[g]        = bus.op_finished;
    assign rd_a[g]         = bus.data_rd;

    psram_backend #(.T_RD(LRD), .T_PAGE(LPG), .T_WR(LWR), .T_GAP(LGP)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .bus       (bus),
      .mem_addr  (addr_a[g]),
      .mem_dq_o  (dq_o_a[g]),
      .mem_dq_oe (dq_oe_a[g]),
      .mem_dq_i  (dq_i_a[g]),
      .mem_ce_n  (ce_a[g]),
      .mem_oe_n  (oe_a[g]),
      .mem_we_n  (we_a[g]),
      .mem_adv_n (adv_a[g]),
      .mem_clk   (mclk_a[g]),
      .mem_cre   (cre_a[g]),
      .mem_ub_n  (ub_a[g]),
      .mem_lb_n  (lb_a[g])
    );
  end

  function automatic int p_rd(input int l);  return (l == 0) ? 4 : 2; endfunction
  function automatic int p_pg(input int l);  return (l == 0) ? 2 : 1; endfunction
  function automatic int p_wr(input int l);  return (l == 0) ? 4 : 2; endfunction
  function automatic int p_gap(input int l); return (l == 0) ? 1 : 3; endfunction

  // Power-up content of the PSRAM array.
  function automatic logic [15:0] init_word(input logic [22:0] a);
    return (a == 23'h555555) ? 16'hA5A5 : (a[15:0] ^ 16'h5A3C);
  endfunction

  // PSRAM device model: stores while we_n is low, drives while oe_n is low.
  logic [15:0] pmem [logic [23:0]];
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (!ce_a[l] && !we_a[l]) pmem[{l[0], addr_a[l]}] = dq_o_a[l];
      if (!ce_a[l] && !oe_a[l]) begin
        if (pmem.exists({l[0], addr_a[l]})) dq_i_a[l] = pmem[{l[0], addr_a[l]}];
        else dq_i_a[l] = init_word(addr_a[l]);
      end else begin
        dq_i_a[l] = 16'h0000;
      end
    end
  end

  // Reference memory: what each address should hold after the writes issued.
  logic [15:0] rmem [logic [23:0]];
  function automatic logic [15:0] ref_rd(input int l, input logic [22:0] a);
    if (rmem.exists({l[0], a})) return rmem[{l[0], a}];
    return init_word(a);
  endfunction

  function automatic logic [22:0] word_addr(input logic [22:0] base, input int k);
    logic [1:0] lo;
    lo = base[1:0] + 2'(k);
    return {base[22:2], lo};
  endfunction

  // {op_begun, data_ok, op_finished, ce_n, oe_n, we_n, dq_oe}
  function automatic logic [6:0] ctl_of(input int l);
    return {begun_a[l], ok_a[l], fin_a[l], ce_a[l], oe_a[l], we_a[l], dq_oe_a[l]};
  endfunction

  localparam logic [6:0] CTL_IDLE = 7'b0001110;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transaction on lane l. The request is presented for one cycle
  // (cycle 0); cycles 1..len are checked. intrude raises a request in
  // cycle 2; rst_at > 0 pulls reset in that cycle and abandons the rest.
  task automatic run_txn(input int l, input bit wr, input bit rd, input bit burst,
                         input logic [22:0] addr, input logic [15:0] data,
                         input bit intrude, input int rst_at);
    int trd, tpg, twr, tgp, np, len, k;
    bit act, ok, wr_low;
    logic [6:0] exp_ctl;
    trd = p_rd(l);
    tpg = p_pg(l);
    twr = p_wr(l);
    tgp = p_gap(l);
    np  = (!wr && burst) ? BURST_LEN - 1 : 0;
    len = wr ? (twr + 1 + tgp) : (trd + np * tpg + tgp);

    @(posedge clk); #1;
    chk("idle_before_req", 32'(ctl_of(l)), 32'(CTL_IDLE));
    app_wr_a[l]    = wr;
    app_rd_a[l]    = rd;
    app_burst_a[l] = burst;
    app_addr_a[l]  = addr;
    app_data_a[l]  = data;

    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      app_wr_a[l]    = 1'b0;
      app_rd_a[l]    = 1'b0;
      app_burst_a[l] = 1'($urandom);
      app_addr_a[l]  = 23'($urandom);
      app_data_a[l]  = 16'($urandom);

      if (wr) begin
        act    = (c <= twr + 1);
        wr_low = (c <= twr);
        ok     = 1'b0;
      end else begin
        act    = (c <= trd + np * tpg);
        wr_low = 1'b0;
        ok     = (c > trd) && (((c - trd - 1) % tpg) == 0) && (((c - trd - 1) / tpg) <= np);
      end
      exp_ctl = {(c == 1), ok, (c == len), !act, (wr | !act), !wr_low, (wr & act)};
      chk(wr ? "wr_ctl" : (burst ? "burst_ctl" : "rd_ctl"), 32'(ctl_of(l)), 32'(exp_ctl));

      if (act) begin
        k = (wr || c <= trd) ? 0 : ((c - trd - 1) / tpg + 1);
        chk("mem_addr", 32'(addr_a[l]), 32'(word_addr(addr, k)));
        if (wr) chk("mem_dq_o", 32'(dq_o_a[l]), 32'(data));
      end
      if (ok) begin
        chk("data_rd", 32'(rd_a[l]), 32'(ref_rd(l, word_addr(addr, (c - trd - 1) / tpg))));
      end

      if (intrude && c == 2) begin
        app_wr_a[l] = 1'($urandom);
        app_rd_a[l] = 1'b1;
      end

      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 32'(ctl_of(l)), 32'(CTL_IDLE));
        chk("rst_mid_addr", 32'(addr_a[l]), 32'h0);
        chk("rst_mid_dq_o", 32'(dq_o_a[l]), 32'h0);
        chk("rst_mid_data_rd", 32'(rd_a[l]), 32'h0);
        repeat (3) begin
          @(posedge clk); #1;
          chk("rst_hold_ctl", 32'(ctl_of(l)), 32'(CTL_IDLE));
        end
        rst_n = 1'b1;
        return;
      end
    end
    if (wr) rmem[{l[0], addr}] = data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kind;
    bit wr, rd, bu;
    logic [22:0] a;

    for (int l = 0; l < 2; l++) begin
      app_wr_a[l]    = 1'b0;
      app_rd_a[l]    = 1'b0;
      app_burst_a[l] = 1'b0;
      app_addr_a[l]  = '0;
      app_data_a[l]  = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk("reset_ctl", 32'(ctl_of(l)), 32'(CTL_IDLE));
      chk("reset_addr", 32'(addr_a[l]), 32'h0);
      chk("reset_data_rd", 32'(rd_a[l]), 32'h0);
      chk("tie_offs", 32'({adv_a[l], mclk_a[l], cre_a[l], ub_a[l], lb_a[l]}), 32'h0);
    end
    rst_n = 1'b1;

    // Directed cases on the default-timing lane.
    run_txn(0, 1'b0, 1'b1, 1'b0, 23'h555555, 16'h0000, 1'b0, 0);
    run_txn(0, 1'b0, 1'b1, 1'b1, 23'h70F0F2, 16'h0000, 1'b0, 0);
    run_txn(0, 1'b1, 1'b0, 1'b0, 23'h0F0F0F, 16'h1234, 1'b1, 0);
    run_txn(0, 1'b0, 1'b1, 1'b0, 23'h0F0F0F, 16'h0000, 1'b0, 0);
    run_txn(0, 1'b1, 1'b1, 1'b1, 23'h000013, 16'hBEEF, 1'b0, 0);
    run_txn(0, 1'b0, 1'b1, 1'b1, 23'h000012, 16'h0000, 1'b1, 0);
    run_txn(0, 1'b0, 1'b1, 1'b1, 23'h70F0F2, 16'h0000, 1'b0, 7);
    run_txn(0, 1'b0, 1'b1, 1'b0, 23'h555555, 16'h0000, 1'b0, 0);

    // Fast-timing lane.
    run_txn(1, 1'b0, 1'b1, 1'b1, 23'h70F0F2, 16'h0000, 1'b0, 0);
    run_txn(1, 1'b1, 1'b0, 1'b0, 23'h123457, 16'hC0DE, 1'b1, 0);
    run_txn(1, 1'b0, 1'b1, 1'b1, 23'h123455, 16'h0000, 1'b0, 0);

    // Random traffic over a small address pool so writes get read back.
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 40; i++) begin
        kind = int'($urandom_range(0, 3));
        wr   = (kind >= 2);
        rd   = (kind != 2);
        bu   = (kind == 1) || ((kind == 3) && ($urandom_range(0, 1) == 1));
        a    = {2'($urandom_range(0, 3)), 17'h0ACE5, 4'($urandom_range(0, 15))};
        run_txn(l, wr, rd, bu, a, 16'($urandom), ($urandom_range(0, 3) == 0), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
